// File: rtl/gcd_stream.sv
// Handshaked GCD engine: one operand pair in, one gcd/zero/cycle-count result out.
// MODE 0 runs subtractive Euclid, MODE 1 runs binary Stein with a common power-of-two count k.
module gcd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int MODE       = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic                  zero_o,
  output logic [CNT_WIDTH-1:0]  cycles_o,
  output logic                  busy_o
);

  localparam int K_WIDTH = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [K_WIDTH-1:0]    r_k;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_gcd;
  logic                  r_zero;
  logic [CNT_WIDTH-1:0]  r_cycles;

  logic [DATA_WIDTH-1:0] w_aStep;
  logic [DATA_WIDTH-1:0] w_bStep;
  logic [K_WIDTH-1:0]    w_kStep;
  logic [CNT_WIDTH-1:0]  w_cntInc;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_zeroIn;
  logic                  w_accept;
  logic                  w_equal;

  assign w_zeroIn = (operand_a_i == '0) || (operand_b_i == '0);
  assign w_accept = in_valid_i & in_ready_o;
  assign w_equal  = (r_a == r_b);
  assign w_cntInc = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);
  assign w_result = r_a << r_k;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = w_zeroIn ? DONE : COMPUTE;
      COMPUTE: if (w_equal) w_nextState = DONE;
      DONE: begin
        if (w_accept)        w_nextState = w_zeroIn ? DONE : COMPUTE;
        else if (out_ready_i) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // in_ready_o is combinational from out_ready_i so a retiring result frees the slot the same cycle
  always_comb begin
    in_ready_o  = (r_state == IDLE) || ((r_state == DONE) && out_ready_i);
    out_valid_o = (r_state == DONE);
    busy_o      = (r_state == COMPUTE);
  end

  // One algorithm step; subtraction is always larger minus smaller so it never wraps
  always_comb begin
    w_aStep = r_a;
    w_bStep = r_b;
    w_kStep = r_k;
    if (MODE == 0) begin
      if (r_a > r_b) w_aStep = r_a - r_b;
      else           w_bStep = r_b - r_a;
    end else begin
      if (!r_a[0] && !r_b[0]) begin
        w_aStep = r_a >> 1;
        w_bStep = r_b >> 1;
        w_kStep = r_k + K_WIDTH'(1);
      end else if (!r_a[0]) begin
        w_aStep = r_a >> 1;
      end else if (!r_b[0]) begin
        w_bStep = r_b >> 1;
      end else if (r_a > r_b) begin
        w_aStep = r_a - r_b;
      end else begin
        w_bStep = r_b - r_a;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_gcd    <= '0;
      r_zero   <= 1'b0;
      r_cycles <= '0;
    end else if (w_accept) begin
      r_a   <= operand_a_i;
      r_b   <= operand_b_i;
      r_k   <= '0;
      r_cnt <= '0;
      if (w_zeroIn) begin
        r_gcd    <= operand_a_i | operand_b_i;
        r_zero   <= 1'b1;
        r_cycles <= '0;
      end else begin
        r_zero   <= 1'b0;
      end
    end else if (r_state == COMPUTE) begin
      r_cnt <= w_cntInc;
      if (w_equal) begin
        r_gcd    <= w_result;
        r_cycles <= w_cntInc;
      end else begin
        r_a <= w_aStep;
        r_b <= w_bStep;
        r_k <= w_kStep;
      end
    end
  end

  assign gcd_o    = r_gcd;
  assign zero_o   = r_zero;
  assign cycles_o = r_cycles;

endmodule

// File: tb/tb_gcd_stream.sv
// Self-checking bench for gcd_stream: one instance per MODE, directed cases plus a
// randomised stream with a scoreboard of expected results.
module tb_gcd_stream;

  localparam int W  = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetSig;
  logic          inValid;
  logic [W-1:0]  opA;
  logic [W-1:0]  opB;
  logic          sel;
  logic          outReadyDir;
  logic          outReadyRnd;
  logic          randomPhase;
  logic          outReady;

  logic          inReady0, outValid0, zero0, busy0;
  logic [W-1:0]  gcd0;
  logic [CW-1:0] cycles0;
  logic          inReady1, outValid1, zero1, busy1;
  logic [W-1:0]  gcd1;
  logic [CW-1:0] cycles1;

  logic          curInReady, curOutValid, curZero, curBusy;
  logic [W-1:0]  curGcd;
  logic [CW-1:0] curCycles;

  assign outReady    = randomPhase ? outReadyRnd : outReadyDir;
  assign curInReady  = sel ? inReady1  : inReady0;
  assign curOutValid = sel ? outValid1 : outValid0;
  assign curZero     = sel ? zero1     : zero0;
  assign curBusy     = sel ? busy1     : busy0;
  assign curGcd      = sel ? gcd1      : gcd0;
  assign curCycles   = sel ? cycles1   : cycles0;

  gcd_stream #(.DATA_WIDTH(W), .MODE(0), .CNT_WIDTH(CW)) dut0 (
    .clk_i(clk), .reset_i(resetSig), .in_valid_i(inValid & ~sel), .in_ready_o(inReady0),
    .operand_a_i(opA), .operand_b_i(opB), .out_valid_o(outValid0), .out_ready_i(outReady & ~sel),
    .gcd_o(gcd0), .zero_o(zero0), .cycles_o(cycles0), .busy_o(busy0)
  );

  gcd_stream #(.DATA_WIDTH(W), .MODE(1), .CNT_WIDTH(CW)) dut1 (
    .clk_i(clk), .reset_i(resetSig), .in_valid_i(inValid & sel), .in_ready_o(inReady1),
    .operand_a_i(opA), .operand_b_i(opB), .out_valid_o(outValid1), .out_ready_i(outReady & sel),
    .gcd_o(gcd1), .zero_o(zero1), .cycles_o(cycles1), .busy_o(busy1)
  );

  typedef struct packed {
    logic [W-1:0]  gcd;
    logic          zero;
    logic [CW-1:0] cycles;
  } job_t;

  job_t         sbQueue[$];
  job_t         expJob;
  job_t         newJob;
  int           checkCount  = 0;
  int           errorCount  = 0;
  int           acceptCount = 0;
  int           retireCount = 0;
  logic         prevHold    = 1'b0;
  logic [W-1:0] holdGcd     = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference gcd by remainder Euclid, independent of either hardware algorithm
  function automatic logic [W-1:0] euclidRef(input logic [W-1:0] a, input logic [W-1:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // Cycle count: one cycle per step plus the final equality cycle, saturating
  function automatic logic [CW-1:0] cycleRef(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
    int x = a;
    int y = b;
    int cnt = 0;
    if (a == 0 || b == 0) return '0;
    while (1) begin
      cnt++;
      if (x == y) break;
      if (!mode) begin
        if (x > y) x = x - y; else y = y - x;
      end else begin
        if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
        else if (x % 2 == 0) x = x / 2;
        else if (y % 2 == 0) y = y / 2;
        else if (x > y) x = x - y;
        else y = y - x;
      end
    end
    if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
    return CW'(cnt);
  endfunction

  // Handshakes are observed on the falling edge; they complete on the following rising edge
  always @(negedge clk) begin
    if (resetSig) begin
      sbQueue.delete();
      prevHold = 1'b0;
    end else begin
      if (prevHold && curOutValid) checkOutput("holdGcd", curGcd, holdGcd);
      if (curOutValid && outReady) begin
        retireCount++;
        if (sbQueue.size() == 0) begin
          checkOutput("spuriousResult", 1, 0);
        end else begin
          expJob = sbQueue.pop_front();
          checkOutput("sbGcd", curGcd, expJob.gcd);
          checkOutput("sbZero", curZero, expJob.zero);
          checkOutput("sbCycles", curCycles, expJob.cycles);
        end
      end
      if (inValid && curInReady) begin
        acceptCount++;
        newJob.gcd    = euclidRef(opA, opB);
        newJob.zero   = (opA == 0) || (opB == 0);
        newJob.cycles = cycleRef(sel, opA, opB);
        sbQueue.push_back(newJob);
      end
      prevHold = curOutValid && !outReady;
      holdGcd  = curGcd;
    end
  end

  always @(posedge clk) begin
    #1 outReadyRnd = ($urandom_range(0, 3) != 0);
  end

  // Present a pair and hold it until accepted; returns just after the accepting edge
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    int waitCycles = 0;
    opA     = a;
    opB     = b;
    inValid = 1'b1;
    @(negedge clk);
    while (!curInReady && waitCycles < 3000) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!curInReady) checkOutput("acceptTimeout", 0, 1);
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  task automatic runJob(input logic [W-1:0] a, input logic [W-1:0] b, output int latency);
    applyStimulus(a, b);
    latency = 1;
    @(negedge clk);
    while (!curOutValid && latency < 1000) begin
      @(posedge clk);
      latency++;
      @(negedge clk);
    end
    if (!curOutValid) checkOutput("resultTimeout", 0, 1);
  endtask

  task automatic retireResult();
    @(posedge clk);
    #1 outReadyDir = 1'b1;
    @(posedge clk);
    #1 outReadyDir = 1'b0;
  endtask

  task automatic randomRun(input logic mode, input int n);
    int baseAcc;
    int baseRet;
    int gap;
    int drainCycles = 0;
    logic [W-1:0] a;
    logic [W-1:0] b;
    sel         = mode;
    baseAcc     = acceptCount;
    baseRet     = retireCount;
    randomPhase = 1'b1;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      a = mode ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 255));
      b = mode ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) a = '0;
      applyStimulus(a, b);
    end
    while (sbQueue.size() != 0 && drainCycles < 5000) begin
      @(posedge clk);
      drainCycles++;
    end
    #1;
    checkOutput("drainQueue", sbQueue.size(), 0);
    checkOutput("jobsAccepted", acceptCount - baseAcc, n);
    checkOutput("jobsRetired", retireCount - baseRet, n);
    randomPhase = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    resetSig    = 1'b1;
    inValid     = 1'b0;
    opA         = '0;
    opB         = '0;
    sel         = 1'b0;
    outReadyDir = 1'b0;
    randomPhase = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetSig = 1'b0;

    @(negedge clk);
    checkOutput("rstInReady0", inReady0, 1);
    checkOutput("rstOutValid0", outValid0, 0);
    checkOutput("rstBusy0", busy0, 0);
    checkOutput("rstGcd0", gcd0, 0);
    checkOutput("rstZero0", zero0, 0);
    checkOutput("rstCycles0", cycles0, 0);
    checkOutput("rstInReady1", inReady1, 1);
    checkOutput("rstOutValid1", outValid1, 0);
    checkOutput("rstBusy1", busy1, 0);
    checkOutput("rstGcd1", gcd1, 0);
    @(posedge clk);
    #1;

    $display("[TB] Euclid 12,8");
    sel = 1'b0;
    runJob(16'd12, 16'd8, lat);
    checkOutput("e12_8Latency", lat, 4);
    checkOutput("e12_8Gcd", curGcd, 4);
    checkOutput("e12_8Cycles", curCycles, 3);
    checkOutput("e12_8Zero", curZero, 0);
    retireResult();

    $display("[TB] Stein 12,8");
    sel = 1'b1;
    runJob(16'd12, 16'd8, lat);
    checkOutput("s12_8Latency", lat, 7);
    checkOutput("s12_8Gcd", curGcd, 4);
    checkOutput("s12_8Cycles", curCycles, 6);
    retireResult();

    $display("[TB] zero operands");
    sel = 1'b0;
    runJob(16'd0, 16'd9, lat);
    checkOutput("z0_9Latency", lat, 1);
    checkOutput("z0_9Gcd", curGcd, 9);
    checkOutput("z0_9Zero", curZero, 1);
    checkOutput("z0_9Cycles", curCycles, 0);
    retireResult();
    runJob(16'd0, 16'd0, lat);
    checkOutput("z0_0Gcd", curGcd, 0);
    checkOutput("z0_0Zero", curZero, 1);
    retireResult();

    $display("[TB] back-pressure then same-cycle accept");
    runJob(16'd12, 16'd8, lat);
    @(posedge clk);
    #1;
    opA     = 16'd35;
    opB     = 16'd21;
    inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpInReady", curInReady, 0);
      checkOutput("bpOutValid", curOutValid, 1);
      checkOutput("bpGcd", curGcd, 4);
      checkOutput("bpCycles", curCycles, 3);
      @(posedge clk);
      #1;
    end
    outReadyDir = 1'b1;
    @(negedge clk);
    checkOutput("bpReleaseReady", curInReady, 1);
    @(posedge clk);
    #1;
    outReadyDir = 1'b0;
    inValid     = 1'b0;
    @(negedge clk);
    checkOutput("bpNewBusy", curBusy, 1);
    checkOutput("bpNewNotValid", curOutValid, 0);
    lat = 0;
    while (!curOutValid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("bp35_21Gcd", curGcd, 7);
    retireResult();

    $display("[TB] reset mid-compute");
    applyStimulus(16'd65535, 16'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("midBusy", curBusy, 1);
    @(posedge clk);
    #1 resetSig = 1'b1;
    @(posedge clk);
    #1 resetSig = 1'b0;
    @(negedge clk);
    checkOutput("abortOutValid", curOutValid, 0);
    checkOutput("abortInReady", curInReady, 1);
    checkOutput("abortBusy", curBusy, 0);
    @(posedge clk);
    #1;
    runJob(16'd9, 16'd6, lat);
    checkOutput("post9_6Gcd", curGcd, 3);
    retireResult();

    $display("[TB] random stream, Euclid");
    randomRun(1'b0, 500);
    $display("[TB] random stream, Stein");
    randomRun(1'b1, 500);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
